pc_fetch_ctrl: RTL and testbench

- Program-counter sequencer for the MIPS core. Owns the PC register, issues instruction-fetch requests, and merges redirect requests from decode and execute: jump (26-bit index), taken branch, and jr.
- Builds each target with the shift-left-two rules: jump target {pc4[31:28], idx, 2'b00}; branch target pc4 + (offset<<2).
- Generates pipeline flush pulses.
- Sits between instruction memory and the IF/ID register.

---
 rtl/pc_fetch_pkg.sv | 49 ++++
 rtl/next_pc_target.sv | 47 ++++
 rtl/pc_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types for the PC fetch sequencer: FSM states, redirect sources,
// the redirect payload and the redirect priority ordering.
package pc_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Encoding order matches priority so the rank is simply the code.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_JR     = 2'd3
  } redir_src_e;

  typedef struct packed {
    redir_src_e      src;
    logic [XLEN-1:0] target;
  } redirect_t;

  localparam redirect_t REDIRECT_NONE = '{src: SRC_NONE, target: '0};

  // Rank of a redirect source; higher wins.
  function automatic logic [1:0] redir_prio(input redir_src_e src);
    logic [1:0] rank;
    case (src)
      SRC_JR:     rank = 2'd3;
      SRC_BRANCH: rank = 2'd2;
      SRC_JUMP:   rank = 2'd1;
      default:    rank = 2'd0;
    endcase
    return rank;
  endfunction

  // Redirects raised by the execute stage also flush ID/EX.
  function automatic logic is_exec_src(input redir_src_e src);
    return (src == SRC_BRANCH) || (src == SRC_JR);
  endfunction

endpackage

// File: rtl/next_pc_target.sv
// Combinational redirect target generation and arbitration.
// Ports:
//   jump_i/jump_idx_i/dec_pc4_i    decode-stage j/jal request
//   branch_i/branch_off_i/ex_pc4_i execute-stage taken branch
//   jr_i/jr_addr_i                 execute-stage jr
//   win_c                          highest-priority redirect this cycle (SRC_NONE if none)
//   misalign_c                     jr requested with a non word-aligned address
module next_pc_target
  import pc_fetch_pkg::*;
(
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_idx_i,
  input  logic [XLEN-1:0]   dec_pc4_i,
  input  logic              branch_i,
  input  logic [XLEN-1:0]   branch_off_i,
  input  logic [XLEN-1:0]   ex_pc4_i,
  input  logic              jr_i,
  input  logic [XLEN-1:0]   jr_addr_i,
  output redirect_t         win_c,
  output logic              misalign_c
);

  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jr_tgt;

  // Jump keeps the 256 MB region of the decode PC+4.
  assign jump_tgt   = (dec_pc4_i & 32'hF000_0000) | XLEN'({jump_idx_i, 2'b00});
  // Shifting the full offset drops bits 31:30, i.e. {off[29:0], 2'b00}.
  assign branch_tgt = ex_pc4_i + (branch_off_i << 2);
  assign jr_tgt     = jr_addr_i & 32'hFFFF_FFFC;

  assign misalign_c = jr_i && (jr_addr_i[1:0] != 2'b00);

  // Execute beats decode; within execute, jr beats branch.
  always_comb begin
    win_c = REDIRECT_NONE;
    if (jr_i) begin
      win_c = '{src: SRC_JR, target: jr_tgt};
    end else if (branch_i) begin
      win_c = '{src: SRC_BRANCH, target: branch_tgt};
    end else if (jump_i) begin
      win_c = '{src: SRC_JUMP, target: jump_tgt};
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: owns the PC, issues instruction fetches,
// buffers one instruction while IF/ID stalls, and merges jump/branch/jr
// redirects with pipeline flush generation.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-low reset
//   imem_req_o/imem_addr_o                fetch request and address
//   imem_ack_i/imem_data_i                fetch completion and instruction word
//   instr_valid_o/instr_o/pc4_o           instruction handed to IF/ID
//   stall_i                               IF/ID not ready
//   jump_i/jump_idx_i/dec_pc4_i           decode redirect
//   branch_i/branch_off_i/ex_pc4_i        execute branch redirect
//   jr_i/jr_addr_i                        execute register-jump redirect
//   flush_id_o/flush_ex_o                 pipeline flush pulses
//   misalign_o                            sticky misaligned-jr flag
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [XLEN-1:0]   imem_data_i,
  output logic              instr_valid_o,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc4_o,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_idx_i,
  input  logic [XLEN-1:0]   dec_pc4_i,
  input  logic              branch_i,
  input  logic [XLEN-1:0]   branch_off_i,
  input  logic              jr_i,
  input  logic [XLEN-1:0]   jr_addr_i,
  input  logic [XLEN-1:0]   ex_pc4_i,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              misalign_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  redirect_t       pend_q, pend_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            misalign_q, misalign_d;

  redirect_t       win_c;
  logic            misalign_c;
  logic [XLEN-1:0] pc_plus4;
  logic            have_redir;
  logic            active;

  next_pc_target u_target (
    .jump_i       (jump_i),
    .jump_idx_i   (jump_idx_i),
    .dec_pc4_i    (dec_pc4_i),
    .branch_i     (branch_i),
    .branch_off_i (branch_off_i),
    .ex_pc4_i     (ex_pc4_i),
    .jr_i         (jr_i),
    .jr_addr_i    (jr_addr_i),
    .win_c        (win_c),
    .misalign_c   (misalign_c)
  );

  assign pc_plus4   = pc_q + PC_STEP;
  assign have_redir = (win_c.src != SRC_NONE);
  assign active     = (state_q != ST_BOOT);

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= REDIRECT_NONE;
      buf_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    buf_d         = buf_q;
    misalign_d    = misalign_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    instr_o       = '0;
    pc4_o         = '0;
    flush_id_o    = 1'b0;
    flush_ex_o    = 1'b0;

    // Redirects are ignored during BOOT; otherwise any presented redirect flushes.
    if (active) begin
      flush_id_o = have_redir;
      flush_ex_o = is_exec_src(win_c.src);
      misalign_d = misalign_q | misalign_c;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (!imem_ack_i) begin
          // Address must stay stable, so park the redirect until the ack.
          if (have_redir && (redir_prio(win_c.src) >= redir_prio(pend_q.src))) begin
            pend_d = win_c;
          end
        end else if (is_exec_src(win_c.src)) begin
          pc_d   = win_c.target;
          pend_d = REDIRECT_NONE;
        end else if (pend_q.src != SRC_NONE) begin
          pc_d   = pend_q.target;
          pend_d = REDIRECT_NONE;
        end else if (have_redir) begin
          pc_d = win_c.target;
        end else begin
          instr_valid_o = 1'b1;
          instr_o       = imem_data_i;
          pc4_o         = pc_plus4;
          if (!stall_i) begin
            pc_d = pc_plus4;
          end else begin
            buf_d   = imem_data_i;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Pending is always empty here: HOLD is only entered on a clean ack.
        if (have_redir) begin
          pc_d    = win_c.target;
          state_d = ST_FETCH;
        end else begin
          instr_valid_o = 1'b1;
          instr_o       = buf_q;
          pc4_o         = pc_plus4;
          if (!stall_i) begin
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc4_o;
  logic        stall_i;
  logic        jump_i;
  logic [25:0] jump_idx_i;
  logic [31:0] dec_pc4_i;
  logic        branch_i;
  logic [31:0] branch_off_i;
  logic        jr_i;
  logic [31:0] jr_addr_i;
  logic [31:0] ex_pc4_i;
  logic        flush_id_o;
  logic        flush_ex_o;
  logic        misalign_o;

  always #5 clk_i = ~clk_i;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc4_o         (pc4_o),
    .stall_i       (stall_i),
    .jump_i        (jump_i),
    .jump_idx_i    (jump_idx_i),
    .dec_pc4_i     (dec_pc4_i),
    .branch_i      (branch_i),
    .branch_off_i  (branch_off_i),
    .jr_i          (jr_i),
    .jr_addr_i     (jr_addr_i),
    .ex_pc4_i      (ex_pc4_i),
    .flush_id_o    (flush_id_o),
    .flush_ex_o    (flush_ex_o),
    .misalign_o    (misalign_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=boot, 1=fetching, 2=holding a stalled word.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_buf;
  bit          m_pend;
  int          m_pend_rank;
  logic [31:0] m_pend_tgt;
  bit          m_mis;

  // This cycle's strongest redirect: rank 3=jr, 2=branch, 1=jump, 0=none.
  task automatic redirect_now(output int rank, output logic [31:0] tgt);
    rank = 0;
    tgt  = 32'h0;
    if (jr_i) begin
      rank = 3;
      tgt  = jr_addr_i & 32'hFFFF_FFFC;
    end else if (branch_i) begin
      rank = 2;
      tgt  = ex_pc4_i + branch_off_i * 32'd4;
    end else if (jump_i) begin
      rank = 1;
      tgt  = {dec_pc4_i[31:28], jump_idx_i, 2'b00};
    end
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_pc        = RST_PC;
    m_buf       = 32'h0;
    m_pend      = 0;
    m_pend_rank = 0;
    m_pend_tgt  = 32'h0;
    m_mis       = 0;
  endtask

  task automatic check_outputs();
    int          rank;
    logic [31:0] tgt;
    bit          v;
    redirect_now(rank, tgt);
    check_eq("addr", imem_addr_o, m_pc);
    check_eq("misalign", 32'(misalign_o), 32'(m_mis));
    if (m_mode == 0) begin
      check_eq("req", 32'(imem_req_o), 32'd0);
      check_eq("valid", 32'(instr_valid_o), 32'd0);
      check_eq("instr", instr_o, 32'h0);
      check_eq("pc4", pc4_o, 32'h0);
      check_eq("flush_id", 32'(flush_id_o), 32'd0);
      check_eq("flush_ex", 32'(flush_ex_o), 32'd0);
    end else begin
      check_eq("req", 32'(imem_req_o), (m_mode == 1) ? 32'd1 : 32'd0);
      check_eq("flush_id", 32'(flush_id_o), (rank > 0) ? 32'd1 : 32'd0);
      check_eq("flush_ex", 32'(flush_ex_o), (rank >= 2) ? 32'd1 : 32'd0);
      if (m_mode == 1) v = imem_ack_i && (rank == 0) && !m_pend;
      else             v = (rank == 0);
      check_eq("valid", 32'(instr_valid_o), 32'(v));
      check_eq("instr", instr_o, v ? ((m_mode == 1) ? imem_data_i : m_buf) : 32'h0);
      check_eq("pc4", pc4_o, v ? m_pc + 32'd4 : 32'h0);
    end
  endtask

  task automatic model_step();
    int          rank;
    logic [31:0] tgt;
    redirect_now(rank, tgt);
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (m_mode != 0 && jr_i && jr_addr_i[1:0] != 2'b00) m_mis = 1;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (!imem_ack_i) begin
        if (rank > 0 && rank >= (m_pend ? m_pend_rank : 0)) begin
          m_pend      = 1;
          m_pend_rank = rank;
          m_pend_tgt  = tgt;
        end
      end else if (rank >= 2) begin
        m_pc   = tgt;
        m_pend = 0;
      end else if (m_pend) begin
        m_pc   = m_pend_tgt;
        m_pend = 0;
      end else if (rank == 1) begin
        m_pc = tgt;
      end else if (!stall_i) begin
        m_pc = m_pc + 32'd4;
      end else begin
        m_buf  = imem_data_i;
        m_mode = 2;
      end
    end else begin
      if (rank > 0) begin
        m_pc   = tgt;
        m_mode = 1;
      end else if (!stall_i) begin
        m_pc   = m_pc + 32'd4;
        m_mode = 1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic clear_redirects();
    jump_i   = 1'b0;
    branch_i = 1'b0;
    jr_i     = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b0;
    imem_ack_i   = 1'b0;
    imem_data_i  = 32'h0;
    stall_i      = 1'b0;
    jump_i       = 1'b0;
    jump_idx_i   = 26'h0;
    dec_pc4_i    = 32'h0;
    branch_i     = 1'b0;
    branch_off_i = 32'h0;
    jr_i         = 1'b0;
    jr_addr_i    = 32'h0;
    ex_pc4_i     = 32'h0;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset state and sequential fetch with an ack every cycle.
    tick();
    rst_i      = 1'b1;
    imem_ack_i = 1'b1;
    #1;
    check_eq("boot_req", 32'(imem_req_o), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      imem_data_i = 32'h1000_0000 + 32'(i);
      #1;
      check_eq("seq_addr", imem_addr_o, 32'(i * 4));
      check_eq("seq_valid", 32'(instr_valid_o), 32'd1);
      tick();
    end

    // Jump arriving while the fetch is outstanding.
    imem_ack_i = 1'b0;
    jump_i     = 1'b1;
    jump_idx_i = 26'h0000100;
    dec_pc4_i  = 32'h4000_0010;
    #1;
    check_eq("jmp_flush_id", 32'(flush_id_o), 32'd1);
    tick();
    jump_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("jmp_hold_addr", imem_addr_o, 32'h10);
      check_eq("jmp_flush_once", 32'(flush_id_o), 32'd0);
      tick();
    end
    imem_ack_i = 1'b1;
    #1;
    check_eq("jmp_discard", 32'(instr_valid_o), 32'd0);
    tick();
    check_eq("jmp_target", imem_addr_o, 32'h4000_0400);

    // Stall after an ack holds the word in the buffer.
    imem_data_i = 32'hDEAD_BEEF;
    stall_i     = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_data_i = $urandom;
      #1;
      check_eq("hold_req", 32'(imem_req_o), 32'd0);
      check_eq("hold_instr", instr_o, 32'hDEAD_BEEF);
      tick();
    end
    stall_i = 1'b0;
    tick();
    check_eq("hold_next", imem_addr_o, 32'h4000_0404);

    // Branch and jump together: branch wins, both flushes.
    imem_ack_i   = 1'b1;
    jump_i       = 1'b1;
    branch_i     = 1'b1;
    ex_pc4_i     = 32'h100;
    branch_off_i = 32'hFFFF_FFFE;
    #1;
    check_eq("br_flush_id", 32'(flush_id_o), 32'd1);
    check_eq("br_flush_ex", 32'(flush_ex_o), 32'd1);
    tick();
    clear_redirects();
    check_eq("br_target", imem_addr_o, 32'hF8);

    // Misaligned jr: aligned target, sticky flag.
    jr_i      = 1'b1;
    jr_addr_i = 32'h0000_2003;
    tick();
    clear_redirects();
    check_eq("jr_target", imem_addr_o, 32'h2000);
    check_eq("jr_misalign", 32'(misalign_o), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("jr_sticky", 32'(misalign_o), 32'd1);

    // Reset during a stalled fetch with a pending jump; stale ack ignored.
    imem_ack_i = 1'b0;
    jump_i     = 1'b1;
    tick();
    clear_redirects();
    rst_i = 1'b0;
    tick();
    rst_i      = 1'b1;
    imem_ack_i = 1'b1;
    #1;
    check_eq("rst_stale_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_misalign", 32'(misalign_o), 32'd0);
    tick();
    check_eq("rst_first_addr", imem_addr_o, RST_PC);
    #1;
    check_eq("rst_no_pending", 32'(instr_valid_o), 32'd1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_i        = ($urandom_range(0, 199) != 0);
      imem_ack_i   = ($urandom_range(0, 2) != 0);
      imem_data_i  = $urandom;
      stall_i      = ($urandom_range(0, 2) == 0);
      jump_i       = ($urandom_range(0, 5) == 0);
      jump_idx_i   = 26'($urandom);
      dec_pc4_i    = $urandom;
      branch_i     = ($urandom_range(0, 7) == 0);
      branch_off_i = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      ex_pc4_i     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      jr_i         = ($urandom_range(0, 9) == 0);
      jr_addr_i    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
